// File: rtl/note_pkg.sv
// Shared types and helpers for the note spawner (lane ids, FSM states, LFSR taps).
package note_pkg;

  typedef enum logic [1:0] {YELLOW = 2'd0, RED = 2'd1, GREEN = 2'd2, BLUE = 2'd3} lane_e;
  typedef enum logic [1:0] {IDLE, GAP, PICK, EMIT} spawn_state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned N_LANES   = 4;

  function automatic logic [N_LANES-1:0] lane_onehot(input logic [1:0] lane);
    return N_LANES'(1) << lane;
  endfunction

  // An all-zero Galois LFSR would lock up, so substitute 1.
  function automatic logic [15:0] seed_fix(input logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR stepped once per frame edge; reset loads the (zero-safe) seed.
module lfsr16
  import note_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= seed_fix(seed);
    end else if (step) begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/note_spawner.sv
// Frame-stepped lane spawn scheduler feeding the four sprite rng inputs.
// Optional NOTE_SPAWNER_CHORD_EN: also request the opposite lane when lfsr_q[15] is set.
module note_spawner
  import note_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [7:0]  SPAWN_GAP = 8'd30,
  parameter logic [3:0]  MAX_RETRY = 4'd8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               enable,
  input  logic [N_LANES-1:0] lane_busy,
  output logic [N_LANES-1:0] rng,
  output logic [15:0]        spawn_count,
  output logic [15:0]        lfsr_q
);

  spawn_state_e       state;
  logic [7:0]         gap_cnt;
  logic [3:0]         retry_cnt;
  logic               frame_s1, frame_s2;
  logic               frame_edge;
  lane_e              lane;
  logic [1:0]         lane2;
  logic [N_LANES-1:0] pick_rng;
  logic [8:0]         jit_sum;
  logic [7:0]         jit_gap;
  logic [15:0]        count_inc;

  // Same two-flop edge detect as the sprites so every block steps on one clock.
  assign frame_edge = frame_s1 & ~frame_s2;

  lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .step  (frame_edge),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  always_comb begin
    lane     = lane_e'(lfsr_q[1:0]);
    lane2    = lfsr_q[1:0] + 2'd2;
    jit_sum  = {1'b0, SPAWN_GAP} + {5'b0, lfsr_q[5:2]};
    jit_gap  = jit_sum[8] ? 8'hFF : jit_sum[7:0];
    pick_rng = lane_onehot(lane);
`ifdef NOTE_SPAWNER_CHORD_EN
    if (lfsr_q[15] && !lane_busy[lane2]) begin
      pick_rng = pick_rng | lane_onehot(lane2);
    end
    count_inc = 16'(popcount4(rng));
`else
    count_inc = 16'd1;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      rng         <= '0;
      spawn_count <= '0;
      gap_cnt     <= '0;
      retry_cnt   <= '0;
      frame_s1    <= 1'b0;
      frame_s2    <= 1'b0;
    end else begin
      frame_s1 <= frame_clk;
      frame_s2 <= frame_s1;
      if (frame_edge) begin
        if (!enable) begin
          state <= IDLE;
          rng   <= '0;
        end else begin
          unique case (state)
            IDLE: begin
              state   <= GAP;
              gap_cnt <= SPAWN_GAP;
            end
            GAP: begin
              if (gap_cnt == 8'd0) begin
                state     <= PICK;
                retry_cnt <= '0;
              end else begin
                gap_cnt <= gap_cnt - 8'd1;
              end
            end
            PICK: begin
              if (!lane_busy[lane]) begin
                state <= EMIT;
                rng   <= pick_rng;
              end else if (retry_cnt == MAX_RETRY - 4'd1) begin
                state   <= GAP;
                gap_cnt <= SPAWN_GAP;
              end else begin
                retry_cnt <= retry_cnt + 4'd1;
              end
            end
            EMIT: begin
              state       <= GAP;
              rng         <= '0;
              spawn_count <= spawn_count + count_inc;
              gap_cnt     <= jit_gap;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
